// File: rtl/prog_mem_loader.sv
// 256 x 15-bit unified instruction/data memory with a serial program loader.
// Holds the core in reset during a load, then serves fetches, loads, stores and one I/O byte.
module prog_mem_loader #(
  parameter int unsigned DEPTH  = 256,
  parameter logic [7:0]  IO_ADR = 8'hFF,
  parameter int unsigned WORD_W = 15
) (
  input  logic       ph1,
  input  logic       ph2,
  input  logic       reset,
  input  logic       ld_start,
  input  logic       ld_valid,
  input  logic       ld_bit,
  input  logic       ld_end,
  output logic       cpu_reset,
  input  logic [7:0] Adr,
  input  logic       MemWrite,
  output logic [6:0] MemData1,
  inout  wire  [7:0] MemData2,
  input  logic [7:0] in_port,
  output logic [7:0] out_port,
  output logic       ld_busy
);

  typedef enum logic [1:0] {StIdle, StLoad, StRun} state_e;

  logic [WORD_W-1:0] mem [DEPTH];

  state_e            state_q, state_d, state_m;
  logic [7:0]        addr_q, addr_d, addr_m;
  logic [3:0]        cnt_q, cnt_d, cnt_m;
  logic [WORD_W-1:0] sh_q, sh_d, sh_m;
  logic [7:0]        out_q, out_d, out_m;

  // Pending memory write, captured on ph2 and committed on ph1 with the rest of the state.
  logic              we_d, we_m;
  logic              wlow_d, wlow_m;
  logic [7:0]        wa_d, wa_m;
  logic [WORD_W-1:0] wd_d, wd_m;

  logic              in_run;
  logic [WORD_W-1:0] rd_word;
  logic [7:0]        rd_lo;
  logic              drive_lo;

  assign in_run = (state_q == StRun);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    out_d   = out_q;
    we_d    = 1'b0;
    wlow_d  = 1'b0;
    wa_d    = addr_q;
    wd_d    = sh_q;
    if (reset) begin
      state_d = StIdle;
      addr_d  = 8'h00;
      cnt_d   = 4'd0;
      sh_d    = '0;
      out_d   = 8'h00;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (ld_start) begin
            state_d = StLoad;
            addr_d  = 8'h00;
            cnt_d   = 4'd0;
          end else if (ld_end) begin
            state_d = StRun;
          end
        end
        StLoad: begin
          if (ld_start) begin
            addr_d = 8'h00;
            cnt_d  = 4'd0;
          end else begin
            if (ld_valid) begin
              sh_d = {sh_q[WORD_W-2:0], ld_bit};
              if (cnt_q == 4'(WORD_W - 1)) begin
                we_d   = 1'b1;
                wa_d   = addr_q;
                wd_d   = sh_d;
                addr_d = addr_q + 8'd1;
                cnt_d  = 4'd0;
              end else begin
                cnt_d = cnt_q + 4'd1;
              end
            end
            // A partial word is simply abandoned; the next load clears the count.
            if (ld_end) begin
              state_d = StRun;
            end
          end
        end
        StRun: begin
          if (MemWrite) begin
            if (Adr == IO_ADR) begin
              out_d = MemData2;
            end else begin
              we_d   = 1'b1;
              wlow_d = 1'b1;
              wa_d   = Adr;
              wd_d   = {{(WORD_W-8){1'b0}}, MemData2};
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge ph2) begin
    state_m <= state_d;
    addr_m  <= addr_d;
    cnt_m   <= cnt_d;
    sh_m    <= sh_d;
    out_m   <= out_d;
    we_m    <= we_d;
    wlow_m  <= wlow_d;
    wa_m    <= wa_d;
    wd_m    <= wd_d;
  end

  always_ff @(posedge ph1) begin
    state_q <= state_m;
    addr_q  <= addr_m;
    cnt_q   <= cnt_m;
    sh_q    <= sh_m;
    out_q   <= out_m;
  end

  always_ff @(posedge ph1) begin
    if (we_m) begin
      if (wlow_m) begin
        mem[wa_m][7:0] <= wd_m[7:0];
      end else begin
        mem[wa_m] <= wd_m;
      end
    end
  end

  always_comb begin
    rd_word  = mem[Adr];
    MemData1 = rd_word[WORD_W-1:8];
    rd_lo    = rd_word[7:0];
    if (in_run && (Adr == IO_ADR)) begin
      MemData1 = 7'h00;
      rd_lo    = in_port;
    end
  end

  // The core owns the low byte only during its own stores.
  assign drive_lo  = !(in_run && MemWrite);
  assign MemData2  = drive_lo ? rd_lo : 8'hzz;

  assign cpu_reset = !in_run;
  assign ld_busy   = (state_q == StLoad);
  assign out_port  = out_q;

endmodule

// File: tb/tb_prog_mem_loader.sv
// Directed bench for prog_mem_loader: serial loads, core loads/stores, I/O byte and reset.
module tb_prog_mem_loader;

  logic       ph1 = 1'b0;
  logic       ph2 = 1'b0;
  logic       reset = 1'b1;
  logic       ld_start = 1'b0;
  logic       ld_valid = 1'b0;
  logic       ld_bit = 1'b0;
  logic       ld_end = 1'b0;
  logic [7:0] adr = 8'h00;
  logic       mem_write = 1'b0;
  logic [7:0] in_port = 8'h00;
  logic       tb_drive = 1'b0;
  logic [7:0] tb_val = 8'h00;

  logic       cpu_reset;
  logic [6:0] mem_data1;
  logic [7:0] out_port;
  logic       ld_busy;
  wire  [7:0] mem_data2;

  assign mem_data2 = tb_drive ? tb_val : 8'hzz;

  int n_chk = 0;
  int n_pass = 0;

  prog_mem_loader dut (
    .ph1      (ph1),
    .ph2      (ph2),
    .reset    (reset),
    .ld_start (ld_start),
    .ld_valid (ld_valid),
    .ld_bit   (ld_bit),
    .ld_end   (ld_end),
    .cpu_reset(cpu_reset),
    .Adr      (adr),
    .MemWrite (mem_write),
    .MemData1 (mem_data1),
    .MemData2 (mem_data2),
    .in_port  (in_port),
    .out_port (out_port),
    .ld_busy  (ld_busy)
  );

  // Non-overlapping two-phase clock, 10 time units per cycle.
  initial begin
    forever begin
      #2 ph1 = 1'b1;
      #3 ph1 = 1'b0;
      #2 ph2 = 1'b1;
      #3 ph2 = 1'b0;
    end
  end

  initial begin
    #1000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  task automatic step;
    @(posedge ph1);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic load_word(input logic [14:0] w, input logic end_last);
    for (int i = 14; i >= 0; i--) begin
      ld_valid = 1'b1;
      ld_bit   = w[i];
      ld_end   = (i == 0) && end_last;
      step;
    end
    ld_valid = 1'b0;
    ld_end   = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a, input logic [6:0] e1,
                        input logic [7:0] e2);
    adr = a;
    #1;
    chk({tag, ".hi"}, {9'd0, mem_data1}, {9'd0, e1});
    chk({tag, ".lo"}, {8'd0, mem_data2}, {8'd0, e2});
    step;
  endtask

  task automatic pulse(input int which);
    if (which == 0) reset = 1'b1;
    else if (which == 1) ld_start = 1'b1;
    else ld_end = 1'b1;
    step;
    reset    = 1'b0;
    ld_start = 1'b0;
    ld_end   = 1'b0;
  endtask

  function automatic logic [14:0] word17(input int k);
    if (k == 0) return 15'h1234;
    if (k == 1) return 15'h7F00;
    if (k == 16) return 15'h6ABC;
    return 15'h0000;
  endfunction

  function automatic logic [14:0] word257(input int k);
    if (k == 1) return 15'h1357;
    if (k == 256) return 15'h4321;
    return 15'h0000;
  endfunction

  initial begin
    repeat (3) step;
    chk("rst_cpu_reset", {15'd0, cpu_reset}, 16'd1);
    chk("rst_ld_busy", {15'd0, ld_busy}, 16'd0);
    chk("rst_out_port", {8'd0, out_port}, 16'h0000);
    reset = 1'b0;
    step;

    // Two-word load, then release the core.
    pulse(1);
    chk("load_busy", {15'd0, ld_busy}, 16'd1);
    load_word(15'h1234, 1'b0);
    load_word(15'h7F00, 1'b0);
    ld_end = 1'b1;
    #1;
    chk("end_cycle_cpu_reset", {15'd0, cpu_reset}, 16'd1);
    step;
    ld_end = 1'b0;
    chk("run_cpu_reset", {15'd0, cpu_reset}, 16'd0);
    chk("run_ld_busy", {15'd0, ld_busy}, 16'd0);
    rd_chk("ld_mem1", 8'h01, 7'h7F, 8'h00);
    rd_chk("ld_mem0", 8'h00, 7'h12, 8'h34);

    // Reload 17 words so address 0x10 has a known upper field.
    pulse(0);
    pulse(1);
    for (int k = 0; k < 17; k++) load_word(word17(k), 1'b0);
    pulse(2);

    // Core store to ordinary memory changes only the low byte.
    adr       = 8'h10;
    mem_write = 1'b1;
    tb_drive  = 1'b1;
    tb_val    = 8'hA5;
    step;
    mem_write = 1'b0;
    tb_drive  = 1'b0;
    rd_chk("st10", 8'h10, 7'h6A, 8'hA5);
    rd_chk("st_neighbor", 8'h11, 7'h00, 8'h00);

    // I/O byte store and read.
    adr       = 8'hFF;
    mem_write = 1'b1;
    tb_drive  = 1'b1;
    tb_val    = 8'h3C;
    step;
    mem_write = 1'b0;
    tb_drive  = 1'b0;
    chk("io_out_port", {8'd0, out_port}, 16'h003C);
    in_port = 8'h81;
    rd_chk("io_rd", 8'hFF, 7'h00, 8'h81);

    // Loader inputs in RUN have no effect.
    ld_start = 1'b1;
    ld_valid = 1'b1;
    ld_bit   = 1'b1;
    step;
    ld_start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      ld_valid = i[0];
      step;
    end
    ld_valid = 1'b0;
    chk("run_ignore_cpu_reset", {15'd0, cpu_reset}, 16'd0);
    chk("run_ignore_busy", {15'd0, ld_busy}, 16'd0);
    rd_chk("run_ignore_mem0", 8'h00, 7'h12, 8'h34);

    // Synchronous reset from RUN.
    reset = 1'b1;
    #1;
    chk("reset_sync", {15'd0, cpu_reset}, 16'd0);
    step;
    reset = 1'b0;
    chk("reset_cpu_reset", {15'd0, cpu_reset}, 16'd1);
    chk("reset_out_port", {8'd0, out_port}, 16'h0000);
    chk("reset_busy", {15'd0, ld_busy}, 16'd0);
    rd_chk("retain10", 8'h10, 7'h6A, 8'hA5);

    // Partial word discarded on ld_end.
    pulse(1);
    for (int i = 0; i < 7; i++) begin
      ld_valid = 1'b1;
      ld_bit   = 1'b1;
      step;
    end
    ld_valid = 1'b0;
    pulse(2);
    chk("partial_run", {15'd0, cpu_reset}, 16'd0);
    rd_chk("partial_mem0", 8'h00, 7'h12, 8'h34);

    // ld_end with the 15th bit: word written, then RUN.
    pulse(0);
    pulse(1);
    load_word(15'h2AAA, 1'b1);
    chk("coinc_run", {15'd0, cpu_reset}, 16'd0);
    rd_chk("coinc_mem0", 8'h00, 7'h2A, 8'hAA);
    rd_chk("coinc_mem1", 8'h01, 7'h7F, 8'h00);

    // Restart mid-word, then 257 words wrap onto address 0.
    pulse(0);
    pulse(1);
    for (int i = 0; i < 5; i++) begin
      ld_valid = 1'b1;
      ld_bit   = 1'b1;
      step;
    end
    ld_valid = 1'b0;
    pulse(1);
    for (int k = 0; k < 257; k++) load_word(word257(k), 1'b0);
    chk("wrap_busy", {15'd0, ld_busy}, 16'd1);
    rd_chk("wrap_mem0", 8'h00, 7'h43, 8'h21);
    rd_chk("wrap_mem1", 8'h01, 7'h13, 8'h57);
    pulse(2);
    chk("wrap_run", {15'd0, cpu_reset}, 16'd0);
    rd_chk("wrap_run_mem10", 8'h10, 7'h00, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
